// File: rtl/counter_pkg.sv
// Shared types for the counter family of blocks.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: cnt_mode_t selects wrap-around or saturating behaviour at the count boundaries.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,  // modulo MAX_VAL+1
    CNT_SAT  = 1'b1   // hold at the boundary
  } cnt_mode_t;

endpackage

// File: rtl/updown_counter_if.sv
// Control/status bundle of the up/down counter.
// Latency: none (wires only). Backpressure: none, the counter accepts every cycle.
// Ports: clr, load, load_val, en, up_dn driven by master; count, tc, ovf, unf driven by slave.
interface updown_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             unf;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  count, tc, ovf, unf
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output count, tc, ovf, unf
  );

endinterface

// File: rtl/counter_prescaler.sv
// Step strobe generator: tick is high on every PRESCALE-th enabled cycle.
// Latency: tick is combinational from en and the registered phase. Backpressure: none.
// Ports: clk, rst (async, active-high), clr (sync phase reset), en (advance), tick (step strobe).
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE must be >= 1");
  end

  if (PRESCALE == 1) begin : g_bypass
    // No phase to keep: every enabled cycle is a step.
    logic unused_ok;
    assign unused_ok = clk ^ rst ^ clr;
    assign tick      = en;
  end else begin : g_div
    localparam int unsigned     PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // Phase holds while en is low, so a gap in en delays the next step by its length.
    always_comb begin
      pre_d = pre_q;
      if (clr) begin
        pre_d = '0;
      end else if (en) begin
        pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
    end

    assign tick = en & (pre_q == LAST);
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with prescaler, clear, clamped load, terminal count and ovf/unf pulses.
// Latency: count/ovf/unf update on the edge ending a step cycle; tc is combinational. Backpressure: none.
// Ports: clk, rst (async, active-high), bus (slave side of updown_counter_if).
module updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter cnt_mode_t   MODE     = CNT_WRAP,
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  updown_counter_if.slave   bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("updown_counter: WIDTH must be >= 1");
  end
  if (MAX_VAL < 1 || (WIDTH < 32 && MAX_VAL > (2 ** WIDTH) - 1)) begin : g_bad_max
    $error("updown_counter: MAX_VAL must be in 1 .. 2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tick;
  logic             at_max;
  logic             at_zero;

  // clr and load both restart the step interval from zero.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.clr | bus.load),
    .en   (bus.en),
    .tick (tick)
  );

  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      // Clamp keeps a non-power-of-2 range closed even for oversized loads.
      count_d = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;
    end else if (tick) begin
      if (bus.up_dn) begin
        if (at_max) begin
          ovf_d   = 1'b1;
          count_d = (MODE == CNT_SAT) ? MAX_C : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          unf_d   = 1'b1;
          count_d = (MODE == CNT_SAT) ? '0 : MAX_C;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  // Terminal count tracks the live direction, not the one sampled at the last step.
  assign bus.tc    = bus.up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (wrap, saturate, prescale-by-3) share one stimulus.
// A behavioural model pushes expected count/ovf/unf per instance; results are popped after each edge.
module tb_updown_counter;
  import counter_pkg::*;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr, load, en, up_dn;
  logic [3:0] load_val;

  always #5 clk = ~clk;

  updown_counter_if #(.WIDTH(4)) if_w ();
  updown_counter_if #(.WIDTH(4)) if_s ();
  updown_counter_if #(.WIDTH(4)) if_p ();

  assign if_w.clr = clr; assign if_w.load = load; assign if_w.load_val = load_val;
  assign if_w.en  = en;  assign if_w.up_dn = up_dn;
  assign if_s.clr = clr; assign if_s.load = load; assign if_s.load_val = load_val;
  assign if_s.en  = en;  assign if_s.up_dn = up_dn;
  assign if_p.clr = clr; assign if_p.load = load; assign if_p.load_val = load_val;
  assign if_p.en  = en;  assign if_p.up_dn = up_dn;

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_WRAP), .PRESCALE(1))
    dut_w (.clk(clk), .rst(rst), .bus(if_w));
  updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_SAT), .PRESCALE(1))
    dut_s (.clk(clk), .rst(rst), .bus(if_s));
  updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_WRAP), .PRESCALE(3))
    dut_p (.clk(clk), .rst(rst), .bus(if_p));

  typedef struct {
    int         dut;
    logic [3:0] count;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    m_cnt[3];
  int    m_pre[3];
  int    ovf_seen[3];
  int    unf_seen[3];
  string phase = "reset";

  function automatic int pres_of(int d);
    return (d == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int d, output logic [3:0] c, output logic o, output logic u,
                         output logic t);
    case (d)
      0:       begin c = if_w.count; o = if_w.ovf; u = if_w.unf; t = if_w.tc; end
      1:       begin c = if_s.count; o = if_s.ovf; u = if_s.unf; t = if_s.tc; end
      default: begin c = if_p.count; o = if_p.ovf; u = if_p.unf; t = if_p.tc; end
    endcase
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0;
      m_pre[d] = 0;
    end
  endtask

  task automatic chk_reset_state();
    logic [3:0] c;
    logic       o, u, t;
    for (int d = 0; d < 3; d++) begin
      get_obs(d, c, o, u, t);
      chk($sformatf("d%0d_rst_count", d), c, 0);
      chk($sformatf("d%0d_rst_ovf", d), o, 0);
      chk($sformatf("d%0d_rst_unf", d), u, 0);
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cyc();
    exp_t       e;
    logic [3:0] c;
    logic       o, u, t;
    logic       exp_tc;
    for (int d = 0; d < 3; d++) begin
      e.dut = d;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (clr) begin
        m_cnt[d] = 0;
        m_pre[d] = 0;
      end else if (load) begin
        m_cnt[d] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
        m_pre[d] = 0;
      end else if (en) begin
        if (m_pre[d] == pres_of(d) - 1) begin
          m_pre[d] = 0;
          if (up_dn) begin
            if (m_cnt[d] == MAXV) begin e.ovf = 1'b1; m_cnt[d] = (d == 1) ? MAXV : 0; end
            else m_cnt[d]++;
          end else begin
            if (m_cnt[d] == 0) begin e.unf = 1'b1; m_cnt[d] = (d == 1) ? 0 : MAXV; end
            else m_cnt[d]--;
          end
        end else begin
          m_pre[d]++;
        end
      end
      e.count = 4'(m_cnt[d]);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      get_obs(e.dut, c, o, u, t);
      exp_tc = up_dn ? (e.count == 4'(MAXV)) : (e.count == 4'd0);
      chk($sformatf("d%0d_count", e.dut), c, e.count);
      chk($sformatf("d%0d_ovf", e.dut), o, e.ovf);
      chk($sformatf("d%0d_unf", e.dut), u, e.unf);
      chk($sformatf("d%0d_tc", e.dut), t, exp_tc);
      if (o === 1'b1) ovf_seen[e.dut]++;
      if (u === 1'b1) unf_seen[e.dut]++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_val = 4'd0;
    model_reset();
    #12;
    chk_reset_state();
    chk("w_rst_tc_down", if_w.tc, 1);
    @(negedge clk);
    rst = 1'b0;

    // 1: count up through the wrap point.
    phase = "t1_up";
    ovf_seen = '{0, 0, 0};
    en = 1'b1; up_dn = 1'b1;
    repeat (12) cyc();
    chk("w_final", if_w.count, 2);
    chk("s_final", if_s.count, 9);
    chk("p_final", if_p.count, 4);
    chk("w_ovf_pulses", ovf_seen[0], 1);

    // 2: saturating down count from a load of 1.
    phase = "t2_sat_down";
    en = 1'b0; load = 1'b1; load_val = 4'd1;
    cyc();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    unf_seen = '{0, 0, 0};
    repeat (3) cyc();
    chk("s_count", if_s.count, 0);
    chk("s_unf_pulses", unf_seen[1], 2);

    // 3: clamped load, then clr beats a simultaneous load.
    phase = "t3_load_clr";
    en = 1'b0; load = 1'b1; load_val = 4'hF;
    cyc();
    chk("w_clamp", if_w.count, 9);
    clr = 1'b1;
    cyc();
    chk("w_clr_wins", if_w.count, 0);
    clr = 1'b0; load = 1'b0;

    // 4: prescale by 3 with a 2-cycle enable gap.
    phase = "t4_prescale";
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (4) cyc();
    chk("p_after4", if_p.count, 1);
    en = 1'b0;
    repeat (2) cyc();
    en = 1'b1;
    cyc();
    chk("p_slipped_not_yet", if_p.count, 1);
    cyc();
    chk("p_slipped_step", if_p.count, 2);

    // 5: asynchronous reset between edges.
    phase = "t5_async_rst";
    load = 1'b1; load_val = 4'd0;
    cyc();
    load = 1'b0;
    repeat (5) cyc();
    chk("w_before_rst", if_w.count, 5);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state();
    model_reset();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("w_first_after_rst", if_w.count, 1);

    // 6: wrap below zero, then alternate direction every cycle.
    phase = "t6_wrap_down";
    clr = 1'b1; en = 1'b0;
    cyc();
    clr = 1'b0; en = 1'b1; up_dn = 1'b0;
    cyc();
    chk("w_wrap_to_max", if_w.count, 9);
    chk("w_unf", if_w.unf, 1);
    up_dn = 1'b1;
    cyc();
    chk("w_alt_0", if_w.count, 0);
    up_dn = 1'b0;
    cyc();
    chk("w_alt_9", if_w.count, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
